// File: rtl/xmit_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// xmit_arbiter_pkg
// Shared definitions for the serial frame transmitter: default frame header,
// FSM state encoding, header/body bit counts and a clog2 helper used to size
// the grant index.
// -----------------------------------------------------------------------------
package xmit_arbiter_pkg;

    // Frame header; must match the header hard-coded in the framed receiver.
    localparam logic [7:0] MATCH_DEFAULT = 8'hA5;

    // Number of serial bits in the header and in the body of a frame.
    localparam int HDR_BITS  = 8;
    localparam int BODY_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so that a grant index always has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/xmit_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin requester selection. The winner is the first asserted request
// found searching ptr+1, ptr+2, ... modulo NREQ, where ptr is the last granted
// index. ptr is loaded with the winner whenever grant_i is high.
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   req_i        : per-requester request levels
//   grant_i      : a grant is being issued this cycle (updates ptr)
//   winner_o     : combinational index of the selected requester
//   any_o        : combinational OR of all requests
// -----------------------------------------------------------------------------
module rr_arbiter
    import xmit_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = clog2_min1(NREQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    input  logic            grant_i,
    output logic [GW-1:0]   winner_o,
    output logic            any_o
);

    localparam logic [GW-1:0] PTR_RESET = GW'(NREQ - 1);

    logic [GW-1:0] ptr_q;
    logic [GW-1:0] ptr_d;
    logic [GW-1:0] winner_s;
    logic [GW-1:0] idx_s;

    // Winner search: scanning offsets from far to near lets the nearest
    // asserted request after ptr overwrite any farther candidate.
    always_comb begin
        winner_s = ptr_q;
        idx_s    = ptr_q;
        for (int off = NREQ; off >= 1; off--) begin
            idx_s = GW'((int'(ptr_q) + off) % NREQ);
            if (req_i[idx_s]) begin
                winner_s = idx_s;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Pointer next state: follows the winner on every grant.
    always_comb begin
        if (grant_i) begin
            ptr_d = winner_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset value makes requester 0 the first winner.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= PTR_RESET;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign winner_o = winner_s;
    assign any_o    = |req_i;

endmodule

// File: rtl/xmit_arbiter.sv
// -----------------------------------------------------------------------------
// xmit_arbiter
// Serial frame transmitter shared by NREQ requesters. A round-robin winner's
// byte is latched, then the line carries the 8-bit header MATCH followed by the
// 8 data bits, MSB first, one bit per clock. Frames run back-to-back while
// requests are pending.
//
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous active-high reset; aborts any frame in progress
//   req      : per-requester send request (level)
//   data     : flattened bytes, requester i on [8*i+7:8*i]
//   ack      : one-cycle pulse, requester's byte has been latched
//   data_out : registered serial line, 0 when idle
//   busy     : high while a frame bit is on data_out
//   gnt_id   : index of the requester whose frame is on the line
// -----------------------------------------------------------------------------
module xmit_arbiter
    import xmit_arbiter_pkg::*;
#(
    parameter int         NREQ  = 4,
    parameter logic [7:0] MATCH = MATCH_DEFAULT,
    localparam int        GW    = clog2_min1(NREQ)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic              data_out,
    output logic              busy,
    output logic [GW-1:0]     gnt_id
);

    localparam logic [2:0] K_HDR_LAST  = 3'(HDR_BITS - 1);
    localparam logic [2:0] K_BODY_LAST = 3'(BODY_BITS - 1);

    state_t          state_q, state_d;
    logic [2:0]      k_q, k_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            data_out_q, data_out_d;
    logic            busy_q, busy_d;
    logic [GW-1:0]   gnt_id_q, gnt_id_d;

    logic            grant_s;
    logic            any_s;
    logic [GW-1:0]   winner_s;
    logic [7:0]      data_a [NREQ];

    // Unflatten the request bytes so the winner can index them directly.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_a[i] = data[8*i +: 8];
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_rr (
        .clock    (clock),
        .reset    (reset),
        .req_i    (req),
        .grant_i  (grant_s),
        .winner_o (winner_s),
        .any_o    (any_s)
    );

    // FSM next state, bit counter, grant and output bit selection.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        shreg_d  = shreg_q;
        gnt_id_d = gnt_id_q;
        ack_d    = '0;
        grant_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_s) begin
                    grant_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HEAD: begin
                if (k_q == K_HDR_LAST) begin
                    state_d = BODY;
                    k_d     = 3'd0;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            BODY: begin
                // Last body bit is a grant point: chain the next frame with no gap.
                if (k_q == K_BODY_LAST) begin
                    if (any_s) begin
                        grant_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                        k_d     = 3'd0;
                    end
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = 3'd0;
            end
        endcase

        if (grant_s) begin
            state_d         = HEAD;
            k_d             = 3'd0;
            shreg_d         = data_a[winner_s];
            gnt_id_d        = winner_s;
            ack_d[winner_s] = 1'b1;
        end else begin
            shreg_d = shreg_d;
        end

        // The line register is loaded with the bit belonging to the next
        // state, so data_out and state_q describe the same cycle.
        // For a 3-bit k, ~k selects bit 7-k (MSB first).
        case (state_d)
            HEAD:    data_out_d = MATCH[~k_d];
            BODY:    data_out_d = shreg_d[~k_d];
            default: data_out_d = 1'b0;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= 3'd0;
            shreg_q    <= 8'h00;
            ack_q      <= '0;
            data_out_q <= 1'b0;
            busy_q     <= 1'b0;
            gnt_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            shreg_q    <= shreg_d;
            ack_q      <= ack_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            gnt_id_q   <= gnt_id_d;
        end
    end

    assign ack      = ack_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign gnt_id   = gnt_id_q;

endmodule

// File: tb/tb_xmit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xmit_arbiter
// Scoreboard bench for xmit_arbiter (NREQ = 4). A frame-level round-robin
// model predicts (requester, byte) for every frame and queues it; a monitor
// deserialises the line like the receiver and compares each completed frame,
// plus ack/gnt_id at frame start and a quiet line between frames.
// -----------------------------------------------------------------------------
module tb_xmit_arbiter;

    localparam int         NREQ  = 4;
    localparam logic [7:0] MATCH = 8'hA5;

    typedef struct {
        int         id;
        logic [7:0] b;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = 4'b0000;
    logic [31:0] data  = 32'h0;
    logic [3:0]  ack;
    logic        data_out;
    logic        busy;
    logic [1:0]  gnt_id;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   model_last = NREQ - 1;

    // Scenario description: bytes per requester, frame counts, re-request gaps.
    logic [7:0] sb [4][4];
    int         sc [4];
    int         gmin [4];
    int         gmax [4];

    int last_run = 0;

    xmit_arbiter #(.NREQ(NREQ), .MATCH(MATCH)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .data_out (data_out),
        .busy     (busy),
        .gnt_id   (gnt_id)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Round-robin rule: first pending requester after the last one served.
    function automatic int rr_next(input logic [3:0] mask, input int last);
        for (int off = 1; off <= NREQ; off++) begin
            if (mask[(last + off) % NREQ]) return (last + off) % NREQ;
        end
        return -1;
    endfunction

    // Monitor / loopback receiver.
    initial begin
        int          fc;
        int          run;
        logic [15:0] sh;
        logic [3:0]  oh;
        exp_t        e;
        fc  = 0;
        run = 0;
        sh  = 16'h0;
        forever begin
            @(negedge clock);
            if (reset) begin
                fc  = 0;
                run = 0;
            end else if (busy) begin
                run++;
                if (fc == 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        oh = 4'b0001 << exp_q[0].id;
                        chk("ack_pulse", {28'h0, ack}, {28'h0, oh});
                        chk("gnt_id", {30'h0, gnt_id}, exp_q[0].id);
                    end
                end else begin
                    chk("ack_extra", {28'h0, ack}, 32'h0);
                end
                sh = {sh[14:0], data_out};
                fc++;
                if (fc == 16) begin
                    fc = 0;
                    chk("header", {24'h0, sh[15:8]}, {24'h0, MATCH});
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("body", {24'h0, sh[7:0]}, {24'h0, e.b});
                    end
                end
            end else begin
                if (run > 0) last_run = run;
                run = 0;
                chk("idle_line", {31'h0, data_out}, 32'h0);
                chk("idle_ack", {28'h0, ack}, 32'h0);
                chk("frame_truncated", fc, 32'd0);
                fc = 0;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        model_last = NREQ - 1;
        chk("rst_data_out", {31'h0, data_out}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ack", {28'h0, ack}, 32'h0);
        chk("rst_gnt_id", {30'h0, gnt_id}, 32'h0);
    endtask

    // Issue one scenario: participants in pm each send sc[i] bytes.
    task automatic run_scn(input logic [3:0] pm);
        int         served [4];
        int         gapc [4];
        int         total;
        int         tot_served;
        int         budget;
        int         lim;
        int         w;
        int         g;
        logic [3:0] mask;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            served[i] = 0;
            gapc[i]   = 0;
            if (pm[i]) total += sc[i];
        end
        // Frame-level model: every unfinished participant is pending at each grant.
        for (int n = 0; n < total; n++) begin
            mask = 4'b0000;
            for (int i = 0; i < NREQ; i++) begin
                if (pm[i] && served[i] < sc[i]) mask[i] = 1'b1;
            end
            w = rr_next(mask, model_last);
            exp_q.push_back('{w, sb[w][served[w]]});
            served[w]++;
            model_last = w;
        end
        for (int i = 0; i < NREQ; i++) begin
            served[i] = 0;
            if (pm[i]) begin
                req[i]         = 1'b1;
                data[8*i +: 8] = sb[i][0];
            end
        end
        budget     = 0;
        tot_served = 0;
        lim        = 16 * total + 40;
        while ((tot_served < total || busy) && budget < lim) begin
            @(posedge clock);
            #1;
            budget++;
            for (int i = 0; i < NREQ; i++) begin
                if (gapc[i] > 0) begin
                    gapc[i]--;
                    if (gapc[i] == 0) req[i] = 1'b1;
                end
                if (ack[i]) begin
                    served[i]++;
                    tot_served++;
                    if (served[i] >= sc[i]) begin
                        req[i] = 1'b0;
                    end else begin
                        data[8*i +: 8] = sb[i][served[i]];
                        g = int'($urandom_range(gmax[i], gmin[i]));
                        if (g > 0) begin
                            req[i]  = 1'b0;
                            gapc[i] = g;
                        end
                    end
                end
            end
        end
        chk("scn_timeout", (budget >= lim) ? 32'd1 : 32'd0, 32'd0);
        req = 4'b0000;
        @(negedge clock);
        #1;
        chk("busy_run", last_run, 16 * total);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic clear_scn();
        for (int i = 0; i < NREQ; i++) begin
            sc[i]   = 0;
            gmin[i] = 0;
            gmax[i] = 0;
            for (int j = 0; j < 4; j++) sb[i][j] = 8'h00;
        end
    endtask

    initial begin
        int wait_n;
        do_reset();

        // Single request from requester 0.
        clear_scn();
        sc[0] = 1; sb[0][0] = 8'h3C;
        run_scn(4'b0001);

        // All four at once from reset: order 0,1,2,3, 64 busy cycles.
        do_reset();
        clear_scn();
        for (int i = 0; i < NREQ; i++) sc[i] = 1;
        sb[0][0] = 8'h11; sb[1][0] = 8'h22; sb[2][0] = 8'h33; sb[3][0] = 8'h44;
        run_scn(4'b1111);

        // Fairness: 0 held high, 2 dropped and re-asserted after each ack.
        clear_scn();
        sc[0] = 4; sc[2] = 4;
        gmin[2] = 1; gmax[2] = 3;
        for (int j = 0; j < 4; j++) begin
            sb[0][j] = 8'(8'h50 + j);
            sb[2][j] = 8'(8'hC0 + j);
        end
        run_scn(4'b0101);

        // Body equal to the header, back-to-back with 0x00.
        clear_scn();
        sc[1] = 2; sb[1][0] = 8'hA5; sb[1][1] = 8'h00;
        run_scn(4'b0010);

        // Idle line.
        req = 4'b0000;
        repeat (100) @(posedge clock);
        #1;

        // Reset at BODY k=3 of a frame from requester 0.
        clear_scn();
        exp_q.push_back('{0, 8'h5A});
        model_last   = 0;
        req[0]       = 1'b1;
        data[7:0]    = 8'h5A;
        wait_n       = 0;
        while (ack[0] !== 1'b1 && wait_n < 30) begin
            @(posedge clock);
            #1;
            wait_n++;
        end
        chk("rst_scn_ack_seen", {31'h0, ack[0]}, 32'h1);
        req[0] = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        chk("pre_reset_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        model_last = NREQ - 1;
        chk("abort_data_out", {31'h0, data_out}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_ack", {28'h0, ack}, 32'h0);
        // Requester 0 must win ahead of 1 after reset.
        sc[0] = 1; sc[1] = 1; sb[0][0] = 8'h77; sb[1][0] = 8'h88;
        run_scn(4'b0011);

        // Randomised scenarios.
        for (int it = 0; it < 20; it++) begin
            logic [3:0] pm;
            clear_scn();
            pm = 4'($urandom_range(15, 1));
            for (int i = 0; i < NREQ; i++) begin
                sc[i]   = int'($urandom_range(3, 1));
                gmin[i] = 0;
                gmax[i] = int'($urandom_range(3, 0));
                for (int j = 0; j < 4; j++) sb[i][j] = 8'($urandom_range(255, 0));
            end
            run_scn(pm);
            repeat (int'($urandom_range(5, 1))) @(posedge clock);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
